// File: rtl/dprob_pkg.sv
// Shared definitions for the per-set probability reduction stage.
package dprob_pkg;

  localparam int FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_NEG_ZERO = 16'h8000;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/dprob_reduce_fp16_gt.sv
// Combinational a > b under fp16 sign-magnitude ordering; +0 and -0 compare equal.
module fp16_gt
  import dprob_pkg::*;
(
  input  logic [FP16_W-1:0] a_i,
  input  logic [FP16_W-1:0] b_i,
  output logic              gt_o
);

  logic a_zero;
  logic b_zero;

  assign a_zero = ((a_i & ~FP16_NEG_ZERO) == FP16_POS_ZERO);
  assign b_zero = ((b_i & ~FP16_NEG_ZERO) == FP16_POS_ZERO);

  // Sign decides first; within a sign, magnitude order flips for negatives.
  always_comb begin
    gt_o = 1'b0;
    if (a_zero && b_zero) begin
      gt_o = 1'b0;
    end else if (a_i[FP16_W-1] != b_i[FP16_W-1]) begin
      gt_o = !a_i[FP16_W-1];
    end else if (!a_i[FP16_W-1]) begin
      gt_o = (a_i[FP16_W-2:0] > b_i[FP16_W-2:0]);
    end else begin
      gt_o = (a_i[FP16_W-2:0] < b_i[FP16_W-2:0]);
    end
  end

endmodule

// File: rtl/floating_point_adder.sv
// Pipelined fp16 adder shared with the upstream per-beat stage.
// Round-to-nearest-even on normals and subnormals; overflow goes to infinity.
module floating_point_adder #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_tdata_i,
  input  logic        a_tvalid_i,
  input  logic [15:0] b_tdata_i,
  input  logic        b_tvalid_i,
  output logic [15:0] result_tdata_o,
  output logic        result_tvalid_o
);

  function automatic logic [11:0] round_rne(input logic [13:0] m);
    logic up;
    up = m[2] & (m[3] | m[1] | m[0]);
    return {1'b0, m[13:3]} + {11'd0, up};
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  ex;
    logic [4:0]  ey;
    logic [4:0]  d;
    logic [5:0]  e;
    logic [13:0] mx;
    logic [13:0] my;
    logic [14:0] s;
    logic [11:0] mr;
    logic        sticky;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
    my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
    d  = ex - ey;
    sticky = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (5'(k) < d) begin
        sticky = sticky | my[0];
        my = my >> 1;
      end
    end
    my[0] = my[0] | sticky;
    if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s == 15'd0) return {x[15] & y[15], 15'd0};
    e = {1'b0, ex};
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      for (int k = 0; k < 13; k++) begin
        if (!s[13] && (e > 6'd1)) begin
          s = s << 1;
          e = e - 6'd1;
        end
      end
    end
    mr = round_rne(s[13:0]);
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 6'd1;
    end
    if (!mr[10]) e = 6'd0;
    if (e >= 6'd31) return {x[15], 5'h1f, 10'd0};
    return {x[15], e[4:0], mr[9:0]};
  endfunction

  logic [15:0] sum_pn [LATENCY];
  logic        vld_pn [LATENCY];

  // Data pipeline: stage 0 computes the sum, later stages only delay it.
  always_ff @(posedge clk) begin
    sum_pn[0] <= fp16_add(a_tdata_i, b_tdata_i);
    for (int k = 1; k < LATENCY; k++) sum_pn[k] <= sum_pn[k-1];
  end

  // Valid pipeline travels alongside the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) vld_pn[k] <= 1'b0;
    end else begin
      vld_pn[0] <= a_tvalid_i & b_tvalid_i;
      for (int k = 1; k < LATENCY; k++) vld_pn[k] <= vld_pn[k-1];
    end
  end

  assign result_tdata_o  = sum_pn[LATENCY-1];
  assign result_tvalid_o = vld_pn[LATENCY-1];

endmodule

// File: rtl/dprob_reduce.sv
// Per-set reduction: running max/min with argmax, serial fp16 sum of beat sums.
module dprob_reduce
  import dprob_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int ADD_LAT   = 3,
  parameter int IDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [FP16_W-1:0] in_max,
  input  logic [FP16_W-1:0] in_min,
  input  logic [FP16_W-1:0] in_sum,
  output logic              busy,
  output logic              overrun,
  output logic              out_valid,
  output logic [FP16_W-1:0] out_max,
  output logic [FP16_W-1:0] out_min,
  output logic [FP16_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_max_beat,
  output logic [IDX_W:0]    out_beats
);

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_BEATS);
  localparam logic [IDX_W:0] ONE_CNT = (IDX_W+1)'(1);

  state_e              state_q, state_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [IDX_W:0]      idx_q, idx_d;
  logic [FP16_W-1:0]   acc_q, acc_d;
  logic [FP16_W-1:0]   run_max_q, run_max_d;
  logic [FP16_W-1:0]   run_min_q, run_min_d;
  logic [IDX_W-1:0]    max_beat_q, max_beat_d;
  logic [FP16_W-1:0]   buf_q [MAX_BEATS];

  logic                overrun_q;
  logic                out_valid_q;
  logic [FP16_W-1:0]   out_max_q, out_min_q, out_sum_q;
  logic [IDX_W-1:0]    out_max_beat_q;
  logic [IDX_W:0]      out_beats_q;

  logic                accept;
  logic                drop;
  logic                max_gt;
  logic                min_gt;
  logic                add_go;
  logic [FP16_W-1:0]   add_res;
  logic                add_res_vld;

  assign accept = (state_q == ST_COLLECT) && in_valid && (count_q < MAX_CNT);
  assign drop   = in_valid && !accept;
  assign add_go = (state_q == ST_ISSUE);

  fp16_gt u_max_gt (
    .a_i  (in_max),
    .b_i  (run_max_q),
    .gt_o (max_gt)
  );

  fp16_gt u_min_gt (
    .a_i  (run_min_q),
    .b_i  (in_min),
    .gt_o (min_gt)
  );

  floating_point_adder #(
    .LATENCY (ADD_LAT)
  ) u_add (
    .clk             (clk),
    .rst             (rst),
    .a_tdata_i       (acc_q),
    .a_tvalid_i      (add_go),
    .b_tdata_i       (buf_q[idx_q[IDX_W-1:0]]),
    .b_tvalid_i      (add_go),
    .result_tdata_o  (add_res),
    .result_tvalid_o (add_res_vld)
  );

  // Next-state and running-statistic updates; adder results honoured only in WAIT.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    run_max_d  = run_max_q;
    run_min_d  = run_min_q;
    max_beat_d = max_beat_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          count_d = count_q + ONE_CNT;
          if (count_q == '0) begin
            run_max_d  = in_max;
            run_min_d  = in_min;
            max_beat_d = '0;
            acc_d      = in_sum;
          end else begin
            if (max_gt) begin
              run_max_d  = in_max;
              max_beat_d = count_q[IDX_W-1:0];
            end
            if (min_gt) run_min_d = in_min;
          end
        end
        // A last beat dropped on a full buffer still closes the set.
        if (in_valid && in_last) begin
          if (count_d == ONE_CNT) begin
            state_d = ST_DONE;
          end else if (count_d > ONE_CNT) begin
            acc_d   = buf_q[0];
            idx_d   = ONE_CNT;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_res_vld) begin
          acc_d   = add_res;
          idx_d   = idx_q + ONE_CNT;
          state_d = (idx_d == count_q) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        count_d = '0;
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
        count_d = '0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath registers, including the partial-sum buffer.
  always_ff @(posedge clk) begin
    acc_q      <= acc_d;
    run_max_q  <= run_max_d;
    run_min_q  <= run_min_d;
    max_beat_q <= max_beat_d;
    if (accept) buf_q[count_q[IDX_W-1:0]] <= in_sum;
  end

  // Result registers load on entry to DONE so out_valid is high during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_max_q      <= '0;
      out_min_q      <= '0;
      out_sum_q      <= '0;
      out_max_beat_q <= '0;
      out_beats_q    <= '0;
    end else begin
      overrun_q   <= drop;
      out_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        out_max_q      <= run_max_d;
        out_min_q      <= run_min_d;
        out_sum_q      <= acc_d;
        out_max_beat_q <= max_beat_d;
        out_beats_q    <= count_d;
      end
    end
  end

  assign busy         = (state_q != ST_COLLECT);
  assign overrun      = overrun_q;
  assign out_valid    = out_valid_q;
  assign out_max      = out_max_q;
  assign out_min      = out_min_q;
  assign out_sum      = out_sum_q;
  assign out_max_beat = out_max_beat_q;
  assign out_beats    = out_beats_q;

endmodule

// File: tb/tb_dprob_reduce.sv
// Directed bench for dprob_reduce with hand-computed fp16 results.
module tb_dprob_reduce;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic [15:0] in_max;
  logic [15:0] in_min;
  logic [15:0] in_sum;
  logic        busy;
  logic        overrun;
  logic        out_valid;
  logic [15:0] out_max;
  logic [15:0] out_min;
  logic [15:0] out_sum;
  logic [2:0]  out_max_beat;
  logic [3:0]  out_beats;

  int checks = 0;
  int errors = 0;
  int ov_total = 0;
  int ovld_total = 0;

  dprob_reduce #(
    .MAX_BEATS (8),
    .ADD_LAT   (3),
    .IDX_W     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_max       (in_max),
    .in_min       (in_min),
    .in_sum       (in_sum),
    .busy         (busy),
    .overrun      (overrun),
    .out_valid    (out_valid),
    .out_max      (out_max),
    .out_min      (out_min),
    .out_sum      (out_sum),
    .out_max_beat (out_max_beat),
    .out_beats    (out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (overrun)   ov_total++;
    if (out_valid) ovld_total++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [15:0] mx, input logic [15:0] mn,
                      input logic [15:0] sm, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    in_max   = mx;
    in_min   = mn;
    in_sum   = sm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Returns cycles after the last-beat cycle until out_valid, or -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_set(input string tag, input int lat, input int elat,
                           input logic [15:0] emax, input logic [15:0] emin,
                           input logic [15:0] esum, input int ebeat, input int ebeats);
    chk({tag, ".lat"},   32'(lat),          32'(elat));
    chk({tag, ".max"},   32'(out_max),      32'(emax));
    chk({tag, ".min"},   32'(out_min),      32'(emin));
    chk({tag, ".sum"},   32'(out_sum),      32'(esum));
    chk({tag, ".mbeat"}, 32'(out_max_beat), 32'(ebeat));
    chk({tag, ".beats"}, 32'(out_beats),    32'(ebeats));
  endtask

  initial begin
    int lat;
    int ov0;
    int vl0;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_max   = '0;
    in_min   = '0;
    in_sum   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ovr",   32'(overrun),   32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
    chk("rst.sum",   32'(out_sum),   32'd0);
    chk("rst.beats", 32'(out_beats), 32'd0);

    // Single-beat set.
    beat(16'h3C00, 16'h3400, 16'h4000, 1'b1);
    wait_out(lat);
    chk("one.busy", 32'(busy), 32'd1);
    check_set("one", lat, 1, 16'h3C00, 16'h3400, 16'h4000, 0, 1);
    @(posedge clk); #1;
    chk("one.vdrop", 32'(out_valid), 32'd0);
    chk("one.idle",  32'(busy),      32'd0);

    // Four back-to-back beats: sum 1+1+2+4 = 8, max tie keeps beat 1.
    beat(16'h3800, 16'h3000, 16'h3C00, 1'b0);
    beat(16'h4200, 16'h2C00, 16'h3C00, 1'b0);
    beat(16'h4200, 16'h3400, 16'h4000, 1'b0);
    beat(16'h3C00, 16'h3800, 16'h4400, 1'b1);
    chk("four.busy", 32'(busy), 32'd1);
    wait_out(lat);
    check_set("four", lat, 13, 16'h4200, 16'h2C00, 16'h4800, 1, 4);
    @(posedge clk); #1;
    chk("four.hold", 32'(out_sum), 32'h4800);

    // Negative ordering; sum 4 - 1 + 1 = 4.
    beat(16'hC000, 16'hBC00, 16'h4400, 1'b0);
    beat(16'hBC00, 16'h3400, 16'hBC00, 1'b0);
    beat(16'hC200, 16'hC000, 16'h3C00, 1'b1);
    wait_out(lat);
    check_set("neg", lat, 9, 16'hBC00, 16'hC000, 16'h4400, 1, 3);
    @(posedge clk); #1;

    // Signed zeros compare equal: first-seen zero is kept.
    beat(16'h3C00, 16'h0000, 16'h3C00, 1'b0);
    beat(16'h3C00, 16'h8000, 16'h3C00, 1'b1);
    wait_out(lat);
    check_set("zpos", lat, 5, 16'h3C00, 16'h0000, 16'h4000, 0, 2);
    @(posedge clk); #1;
    beat(16'h3C00, 16'h8000, 16'h3C00, 1'b0);
    beat(16'h3C00, 16'h0000, 16'h3C00, 1'b1);
    wait_out(lat);
    check_set("zneg", lat, 5, 16'h3C00, 16'h8000, 16'h4000, 0, 2);
    @(posedge clk); #1;

    // Beats presented while busy are dropped, each pulsing overrun.
    ov0 = ov_total;
    vl0 = ovld_total;
    beat(16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    beat(16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    beat(16'h4000, 16'h3C00, 16'h4000, 1'b0);
    beat(16'h3800, 16'h3C00, 16'h4000, 1'b1);
    for (int j = 0; j < 4; j++) begin
      in_valid = (j % 2 == 0);
      in_last  = 1'b1;
      in_max   = 16'h7800;
      in_min   = 16'h8400;
      in_sum   = 16'h7800;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(lat);
    if (lat > 0) lat = lat + 4;
    check_set("busy", lat, 13, 16'h4000, 16'h3C00, 16'h4800, 2, 4);
    @(posedge clk); #1;
    chk("busy.ovr",  32'(ov_total - ov0),   32'd2);
    chk("busy.nvld", 32'(ovld_total - vl0), 32'd1);
    beat(16'h3400, 16'h3000, 16'h3800, 1'b1);
    wait_out(lat);
    check_set("after", lat, 1, 16'h3400, 16'h3000, 16'h3800, 0, 1);
    @(posedge clk); #1;

    // Overflow: nine beats, the ninth carries last and is dropped.
    ov0 = ov_total;
    for (int k = 0; k < 8; k++) begin
      beat((k == 5) ? 16'h4400 : 16'h3C00,
           (k == 6) ? 16'h3000 : 16'h3C00,
           16'h3C00, 1'b0);
    end
    beat(16'h7800, 16'h8400, 16'h7800, 1'b1);
    wait_out(lat);
    check_set("ovf", lat, 29, 16'h4400, 16'h3000, 16'h4800, 5, 8);
    @(posedge clk); #1;
    chk("ovf.ovr", 32'(ov_total - ov0), 32'd1);

    // Reset in the middle of a reduction.
    vl0 = ovld_total;
    beat(16'h3800, 16'h3000, 16'h3C00, 1'b0);
    beat(16'h4200, 16'h2C00, 16'h3C00, 1'b0);
    beat(16'h4200, 16'h3400, 16'h4000, 1'b0);
    beat(16'h3C00, 16'h3800, 16'h4400, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst.busy",  32'(busy),         32'd0);
    chk("mrst.valid", 32'(out_valid),    32'd0);
    chk("mrst.max",   32'(out_max),      32'd0);
    chk("mrst.min",   32'(out_min),      32'd0);
    chk("mrst.sum",   32'(out_sum),      32'd0);
    chk("mrst.mbeat", 32'(out_max_beat), 32'd0);
    chk("mrst.beats", 32'(out_beats),    32'd0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("mrst.nvld", 32'(ovld_total - vl0), 32'd0);
    beat(16'h4000, 16'h3C00, 16'h3C00, 1'b1);
    wait_out(lat);
    check_set("post", lat, 1, 16'h4000, 16'h3C00, 16'h3C00, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
